count8_sched: RTL

Round-robin scheduler that shares one 8-bit loadable up-counter (load/enable/value interface, async active-low reset) among NREQ requesters, each asking for a timed interval of a given length. The block arbitrates requests, loads the counter with zero, enables it until it reaches the winner's latched duration, then pulses that requester's done. It sits between the counter datapath and the requesting blocks; the counter itself stays outside.

---
 rtl/count8_sched_pkg.sv | 14 +
 rtl/count8_sched_rr_arb.sv | 30 +++
 rtl/count8_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/count8_sched_pkg.sv
// Shared types and constants for the count8_sched round-robin interval scheduler.
package count8_sched_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD_VAL = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count8_sched_rr_arb.sv
// Combinational round-robin arbiter: searches req starting one past last, returns one-hot winner and index.
module rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx
);

  logic found;
  int   pos;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = (int'(last) + k) % NREQ;
      if (!found && req[pos]) begin
        found    = 1'b1;
        win[pos] = 1'b1;
        win_idx  = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/count8_sched.sv
// Round-robin scheduler sharing one external 8-bit up-counter among NREQ requesters.
// Optional build macro COUNT8_SCHED_ABORT_EN: owner dropping req in LOAD/RUN aborts the interval.
//
// state | meaning
// IDLE  | waiting for any req; arbitrate and latch winner + dur
// LOAD  | counter loaded with zero
// RUN   | counter incrementing until it equals latched dur
// DONE  | one-cycle done pulse to the owner
module count8_sched
  import count8_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] dur,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_en,
  output logic                  cnt_load,
  output logic [CNT_W-1:0]      cnt_val,
  input  logic [CNT_W-1:0]      cnt
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner, last, win_idx;
  logic [NREQ-1:0]  win, owner_oh;
  logic [CNT_W-1:0] dur_q;
  logic             any_req, match, abort;

  rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx)
  );

  assign any_req  = |win;
  assign match    = (cnt == dur_q);
  assign owner_oh = NREQ'(1) << owner;

`ifdef COUNT8_SCHED_ABORT_EN
  assign abort = ~req[owner];
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= '0;
      dur_q <= '0;
      last  <= LAST_RST;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) begin
        owner <= win_idx;
        dur_q <= dur[win_idx*CNT_W +: CNT_W];
      end
      // an aborted owner also counts as served so the others get their turn first
      if (state == ST_DONE || ((state == ST_LOAD || state == ST_RUN) && abort))
        last <= owner;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort)      state_nxt = ST_IDLE;
        else if (match) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt      = '0;
    done     = '0;
    busy     = 1'b0;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = CNT_LOAD_VAL;
    case (state)
      ST_LOAD: begin
        gnt      = owner_oh;
        busy     = 1'b1;
        cnt_en   = 1'b1;
        cnt_load = 1'b1;
      end
      ST_RUN: begin
        gnt    = owner_oh;
        busy   = 1'b1;
        cnt_en = ~match;
      end
      ST_DONE: begin
        gnt  = owner_oh;
        done = owner_oh;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
